opb_register_simulink2ppc_buf: RTL

OPB slave that returns fabric-generated values to the PowerPC: the opposite direction of the ppc2simulink software register. User logic presents a 32-bit word with a valid strobe. The block captures the word and holds it with valid, overrun and count status. Software reads it over OPB at a fixed 256-byte window in the OPB register map. It runs on a single clock (user side on OPB_Clk), so no CDC is needed.

---
 rtl/opb_s2p_pkg.sv | 27 ++
 rtl/opb_register_simulink2ppc_buf_if.sv | 29 ++
 rtl/opb_slave_ack_fsm.sv | 91 +++++++++
 rtl/opb_register_simulink2ppc_buf.sv | 126 ++++++++++++
 4 files changed

// File: rtl/opb_s2p_pkg.sv
// Shared definitions for the Simulink-to-PPC readback register.
// Holds register word offsets, STATUS/CTRL bit positions and the OPB
// acknowledge FSM state type.
package opb_s2p_pkg;

    // Word offsets within the 256-byte window (OPB_ABus[28:29]).
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;
    localparam logic [1:0] OFS_TSTAMP = 2'd3;

    // STATUS layout (little-endian bit numbering of the 32-bit word).
    localparam int unsigned ST_VALID   = 31;
    localparam int unsigned ST_OVERRUN = 30;
    localparam int unsigned ST_COUNT_W = 16;

    // CTRL layout.
    localparam int unsigned CTRL_CLEAR  = 0;
    localparam int unsigned CTRL_FREEZE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP
    } s2p_state_e;

endpackage

// File: rtl/opb_register_simulink2ppc_buf_if.sv
// OPB slave-side bus bundle for the Simulink-to-PPC readback register.
// Signals keep the OPB big-endian bit numbering ([0] is the MSB).
//   master modport: drives address/data/control, receives slave responses
//   slave  modport: receives address/data/control, drives Sl_* responses
interface opb_register_simulink2ppc_buf_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave front end: window decode, IDLE->ACK->GAP acknowledge sequence,
// read-data register and Sl_DBus gating.
// Ports:
//   OPB_Clk, OPB_Rst_n : clock, asynchronous active-low reset
//   opb                : OPB bus (slave modport)
//   rd_idx  / rd_word  : live word index out, register word for that index in
//   xfer_idx           : word index latched for the transfer in progress
//   rd_ack / wr_ack    : one-cycle strobes during ACK for reads / writes
//   wr_data, wr_be_lsb : write word and byte enable of bits [7:0]
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_0500,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_05FF
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    opb_register_simulink2ppc_buf_if.slave opb,
    output logic [1:0]  rd_idx,
    input  logic [31:0] rd_word,
    output logic [1:0]  xfer_idx,
    output logic        rd_ack,
    output logic        wr_ack,
    output logic [31:0] wr_data,
    output logic        wr_be_lsb
);

    s2p_state_e  state_q, state_d;
    logic [31:0] rdata_q;
    logic [1:0]  idx_q;
    logic        rnw_q;
    logic        load;
    logic        hit;
    logic        ack;
    logic [31:0] addr;

    // Packed [31:0] copy flips OPB bit numbering to conventional LSB-0.
    assign addr   = opb.OPB_ABus;
    assign hit    = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign rd_idx = addr[3:2];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ACK;
                    load    = 1'b1;
                end
            end
            S_ACK:   state_d = S_GAP;
            // Dead cycle so a master still holding select is not acked twice.
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            idx_q   <= '0;
            rnw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rdata_q <= rd_word;
                idx_q   <= rd_idx;
                rnw_q   <= opb.OPB_RNW;
            end
        end
    end

    assign ack       = (state_q == S_ACK);
    assign xfer_idx  = idx_q;
    assign rd_ack    = ack && rnw_q;
    assign wr_ack    = ack && !rnw_q;
    assign wr_data   = opb.OPB_DBus;
    assign wr_be_lsb = opb.OPB_BE[3];

    assign opb.Sl_xferAck = ack;
    assign opb.Sl_DBus    = rd_ack ? rdata_q : '0;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_bus;
    assign unused_bus = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2]};

endmodule

// File: rtl/opb_register_simulink2ppc_buf.sv
// Simulink-to-PPC readback register: captures a fabric word on user_valid and
// exposes it over OPB with valid/overrun/count status and a freeze control.
// Optional feature macro: OPB_S2P_TSTAMP_EN (cycle timestamp of last capture
// at word 3; without it word 3 reads 0).
// Ports:
//   OPB_Clk, OPB_Rst_n        : single clock, asynchronous active-low reset
//   opb                       : OPB bus (slave modport)
//   user_data_in, user_valid  : fabric word and capture strobe
module opb_register_simulink2ppc_buf
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0500,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_05FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    opb_register_simulink2ppc_buf_if.slave opb,
    input  logic [31:0] user_data_in,
    input  logic        user_valid
);

    logic [31:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [ST_COUNT_W-1:0] count_q, count_d;
    logic                  freeze_q, freeze_d;

    logic [1:0]  rd_idx, xfer_idx;
    logic [31:0] rd_word, status_word, tstamp_word;
    logic        rd_ack, wr_ack, wr_be_lsb;
    logic [31:0] wr_data;
    logic        capture, data_read, ctrl_wr, clear;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .OPB_Clk   (OPB_Clk),
        .OPB_Rst_n (OPB_Rst_n),
        .opb       (opb),
        .rd_idx    (rd_idx),
        .rd_word   (rd_word),
        .xfer_idx  (xfer_idx),
        .rd_ack    (rd_ack),
        .wr_ack    (wr_ack),
        .wr_data   (wr_data),
        .wr_be_lsb (wr_be_lsb)
    );

    assign capture   = user_valid && !freeze_q;
    assign data_read = rd_ack && (xfer_idx == OFS_DATA);
    assign ctrl_wr   = wr_ack && (xfer_idx == OFS_CTRL) && wr_be_lsb;
    assign clear     = ctrl_wr && wr_data[CTRL_CLEAR];

    always_comb begin
        status_word                   = '0;
        status_word[ST_VALID]         = valid_q;
        status_word[ST_OVERRUN]       = overrun_q;
        status_word[ST_COUNT_W-1:0]   = count_q;
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            OFS_DATA:   rd_word = data_q;
            OFS_STATUS: rd_word = status_word;
            OFS_CTRL:   rd_word[CTRL_FREEZE] = freeze_q;
            OFS_TSTAMP: rd_word = tstamp_word;
            default:    rd_word = '0;
        endcase
    end

    always_comb begin
        data_d    = capture ? user_data_in : data_q;
        // Capture wins over the read-clear so a word arriving during a DATA
        // read is not lost and is not flagged as an overrun.
        valid_d   = capture ? 1'b1 : (data_read ? 1'b0 : valid_q);
        overrun_d = clear ? 1'b0 : (overrun_q || (capture && valid_q && !data_read));
        count_d   = (clear ? '0 : count_q) + {{(ST_COUNT_W-1){1'b0}}, capture};
        freeze_d  = ctrl_wr ? wr_data[CTRL_FREEZE] : freeze_q;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            freeze_q  <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            freeze_q  <= freeze_d;
        end
    end

`ifdef OPB_S2P_TSTAMP_EN
    logic [31:0] cycle_q, tstamp_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cycle_q  <= '0;
            tstamp_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (capture) begin
                tstamp_q <= cycle_q;
            end
        end
    end

    assign tstamp_word = tstamp_q;
`else
    assign tstamp_word = '0;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{wr_data[31:2], (C_FAMILY != ""), (C_OPB_AWIDTH == 32),
                          (C_OPB_DWIDTH == 32)};

endmodule
